// File: rtl/dca_matrix_lsu_local_responder_pkg.sv
// Shared definitions for the DCA matrix-LSU local responder: instruction layout,
// op encodings and FSM state encodings.
package dca_matrix_lsu_local_responder_pkg;

  typedef enum logic [1:0] {
    OpNop   = 2'b00,
    OpLoad  = 2'b01,
    OpStore = 2'b10,
    OpNop3  = 2'b11
  } lsu_op_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StLoad   = 3'd2,
    StStore  = 3'd3,
    StDone   = 3'd4
  } lsu_state_e;

  // Instruction field layout: [1:0] op, [9:2] nrows_m1, [17:10] stride, [31:18] base.
  localparam int unsigned OpLsb     = 0;
  localparam int unsigned OpW       = 2;
  localparam int unsigned NrowsLsb  = 2;
  localparam int unsigned NrowsW    = 8;
  localparam int unsigned StrideLsb = 10;
  localparam int unsigned StrideW   = 8;
  localparam int unsigned BaseLsb   = 18;

  // Skid entries plus in-flight reads may never exceed this.
  localparam int unsigned SkidDepth = 2;

  // State entered after DECODE for a given op; NOPs finish immediately.
  function automatic lsu_state_e exec_state(input lsu_op_e op);
    lsu_state_e st;
    case (op)
      OpLoad:  st = StLoad;
      OpStore: st = StStore;
      default: st = StDone;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/dca_matrix_lsu_row_skid.sv
// Two-entry fall-through FIFO holding LOAD rows returned by the SRAM while the
// master applies backpressure. An arriving row bypasses straight to the output when empty.
module dca_matrix_lsu_row_skid #(
  parameter int unsigned BW_ROW = 64
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              push,
  input  logic [BW_ROW-1:0] push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [BW_ROW-1:0] out_data,
  output logic [1:0]        count
);

  logic [BW_ROW-1:0] slot_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        cnt_q;
  logic              empty;
  logic              do_write;
  logic              do_read;

  always_comb begin
    empty     = (cnt_q == 2'd0);
    out_valid = !empty || push;
    out_data  = '0;
    if (!empty) begin
      out_data = slot_q[rd_ptr_q];
    end else if (push) begin
      out_data = push_data;
    end
    do_read  = pop && !empty;
    // A row consumed in the same cycle it arrives into an empty FIFO is never stored.
    do_write = push && !(empty && pop);
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (do_write) begin
        slot_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_read) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_write} - {1'b0, do_read};
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/dca_matrix_lsu_local_responder.sv
// LSU responder: takes one instruction at a time, then streams rows out of the local
// SRAM (LOAD) or writes rows arriving from the master into it (STORE).
module dca_matrix_lsu_local_responder
  import dca_matrix_lsu_local_responder_pkg::*;
#(
  parameter int unsigned BW_ROW      = 64,
  parameter int unsigned BW_INST     = 32,
  parameter int unsigned BW_MEM_ADDR = 14
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   sinst_wvalid,
  input  logic [BW_INST-1:0]     sinst_wdata,
  output logic                   sinst_wready,
  output logic                   sinst_decode_finish,
  output logic                   sinst_execute_finish,
  output logic                   sinst_busy,
  output logic                   sload_tensor_row_wvalid,
  output logic                   sload_tensor_row_wlast,
  output logic [BW_ROW-1:0]      sload_tensor_row_wdata,
  input  logic                   sload_tensor_row_wready,
  output logic                   sstore_tensor_row_rvalid,
  output logic                   sstore_tensor_row_rlast,
  input  logic                   sstore_tensor_row_rready,
  input  logic [BW_ROW-1:0]      sstore_tensor_row_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [BW_MEM_ADDR-1:0] mem_addr,
  output logic [BW_ROW-1:0]      mem_wdata,
  input  logic [BW_ROW-1:0]      mem_rdata
);

  localparam int unsigned PadW = BW_MEM_ADDR - StrideW;

  lsu_state_e            state_q;
  lsu_op_e               op_q;
  logic [NrowsW-1:0]     nrows_q;
  logic [StrideW-1:0]    stride_q;
  logic [BW_MEM_ADDR-1:0] addr_q;
  logic [NrowsW:0]       issued_q;
  logic [NrowsW-1:0]     row_cnt_q;
  logic                  inflight_q;
  logic                  wready_q;
  logic                  decode_fin_q;
  logic                  exec_fin_q;
  logic                  busy_q;

  logic                  accept;
  logic                  in_load;
  logic                  in_store;
  logic                  last_row;
  logic                  read_issue;
  logic                  load_hs;
  logic                  store_hs;
  logic [2:0]            occupancy;
  logic [BW_MEM_ADDR-1:0] stride_ext;
  logic                  skid_valid;
  logic [BW_ROW-1:0]     skid_data;
  logic [1:0]            skid_count;

  dca_matrix_lsu_row_skid #(
    .BW_ROW (BW_ROW)
  ) u_row_skid (
    .clk       (clk),
    .rstnn     (rstnn),
    .push      (inflight_q),
    .push_data (mem_rdata),
    .pop       (sload_tensor_row_wready),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .count     (skid_count)
  );

  always_comb begin
    accept     = sinst_wvalid && wready_q;
    in_load    = (state_q == StLoad);
    in_store   = (state_q == StStore);
    last_row   = (row_cnt_q == nrows_q);
    stride_ext = {{PadW{1'b0}}, stride_q};
    // Counting the in-flight read guarantees the returning row always has a free slot.
    occupancy  = {1'b0, skid_count} + {2'b00, inflight_q};
    read_issue = in_load && (issued_q <= {1'b0, nrows_q}) && (occupancy < 3'(SkidDepth));
    load_hs    = skid_valid && sload_tensor_row_wready;
    store_hs   = in_store && sstore_tensor_row_rready;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q      <= StIdle;
      op_q         <= OpNop;
      nrows_q      <= '0;
      stride_q     <= '0;
      addr_q       <= '0;
      issued_q     <= '0;
      row_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      wready_q     <= 1'b0;
      decode_fin_q <= 1'b0;
      exec_fin_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      decode_fin_q <= 1'b0;
      exec_fin_q   <= 1'b0;
      inflight_q   <= read_issue;
      unique case (state_q)
        StIdle: begin
          wready_q <= !accept;
          if (accept) begin
            op_q         <= lsu_op_e'(sinst_wdata[OpLsb +: OpW]);
            nrows_q      <= sinst_wdata[NrowsLsb +: NrowsW];
            stride_q     <= sinst_wdata[StrideLsb +: StrideW];
            addr_q       <= sinst_wdata[BaseLsb +: BW_MEM_ADDR];
            issued_q     <= '0;
            row_cnt_q    <= '0;
            busy_q       <= 1'b1;
            decode_fin_q <= 1'b1;
            state_q      <= StDecode;
          end
        end
        StDecode: begin
          state_q <= exec_state(op_q);
          if (exec_state(op_q) == StDone) begin
            exec_fin_q <= 1'b1;
          end
        end
        StLoad: begin
          if (read_issue) begin
            issued_q <= issued_q + 1'b1;
            addr_q   <= addr_q + stride_ext;
          end
          if (load_hs) begin
            row_cnt_q <= row_cnt_q + 1'b1;
            if (last_row) begin
              state_q    <= StDone;
              exec_fin_q <= 1'b1;
            end
          end
        end
        StStore: begin
          if (store_hs) begin
            addr_q    <= addr_q + stride_ext;
            row_cnt_q <= row_cnt_q + 1'b1;
            if (last_row) begin
              state_q    <= StDone;
              exec_fin_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          wready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sinst_wready         = wready_q;
  assign sinst_decode_finish  = decode_fin_q;
  assign sinst_execute_finish = exec_fin_q;
  assign sinst_busy           = busy_q;

  assign sload_tensor_row_wvalid = skid_valid;
  assign sload_tensor_row_wlast  = skid_valid && last_row;
  assign sload_tensor_row_wdata  = skid_data;

  assign sstore_tensor_row_rvalid = in_store;
  assign sstore_tensor_row_rlast  = in_store && last_row;

  assign mem_req   = read_issue || store_hs;
  assign mem_we    = store_hs;
  assign mem_addr  = addr_q;
  assign mem_wdata = store_hs ? sstore_tensor_row_rdata : '0;

endmodule

// File: tb/tb_dca_matrix_lsu_local_responder.sv
// Directed bench for the LSU local responder with a scoreboard of expected rows,
// SRAM reads and SRAM writes.
module tb_dca_matrix_lsu_local_responder;

  localparam int unsigned BW_ROW      = 64;
  localparam int unsigned BW_INST     = 32;
  localparam int unsigned BW_MEM_ADDR = 14;

  logic                   clk = 1'b0;
  logic                   rstnn;
  logic                   sinst_wvalid;
  logic [BW_INST-1:0]     sinst_wdata;
  logic                   sinst_wready;
  logic                   sinst_decode_finish;
  logic                   sinst_execute_finish;
  logic                   sinst_busy;
  logic                   sload_wvalid;
  logic                   sload_wlast;
  logic [BW_ROW-1:0]      sload_wdata;
  logic                   sload_wready;
  logic                   sstore_rvalid;
  logic                   sstore_rlast;
  logic                   sstore_rready;
  logic [BW_ROW-1:0]      sstore_rdata;
  logic                   mem_req;
  logic                   mem_we;
  logic [BW_MEM_ADDR-1:0] mem_addr;
  logic [BW_ROW-1:0]      mem_wdata;
  logic [BW_ROW-1:0]      mem_rdata;

  always #5 clk = ~clk;

  dca_matrix_lsu_local_responder #(
    .BW_ROW      (BW_ROW),
    .BW_INST     (BW_INST),
    .BW_MEM_ADDR (BW_MEM_ADDR)
  ) dut (
    .clk                      (clk),
    .rstnn                    (rstnn),
    .sinst_wvalid             (sinst_wvalid),
    .sinst_wdata              (sinst_wdata),
    .sinst_wready             (sinst_wready),
    .sinst_decode_finish      (sinst_decode_finish),
    .sinst_execute_finish     (sinst_execute_finish),
    .sinst_busy               (sinst_busy),
    .sload_tensor_row_wvalid  (sload_wvalid),
    .sload_tensor_row_wlast   (sload_wlast),
    .sload_tensor_row_wdata   (sload_wdata),
    .sload_tensor_row_wready  (sload_wready),
    .sstore_tensor_row_rvalid (sstore_rvalid),
    .sstore_tensor_row_rlast  (sstore_rlast),
    .sstore_tensor_row_rready (sstore_rready),
    .sstore_tensor_row_rdata  (sstore_rdata),
    .mem_req                  (mem_req),
    .mem_we                   (mem_we),
    .mem_addr                 (mem_addr),
    .mem_wdata                (mem_wdata),
    .mem_rdata                (mem_rdata)
  );

  function automatic logic [63:0] load_pat(input logic [13:0] a);
    return {2'b01, a, 16'h5A5A, 2'b10, a, 16'hC3C3};
  endfunction

  function automatic logic [63:0] store_pat(input int k);
    return {32'h5700_0000 + 32'(k), 32'hFACE_0000 ^ 32'(k)};
  endfunction

  function automatic logic [31:0] mk_inst(input int op, input int n, input int stride,
                                          input int base);
    return {14'(base), 8'(stride), 8'(n), 2'(op)};
  endfunction

  // SRAM model: 1-cycle read latency, garbage on the bus when no read was issued.
  always @(posedge clk) begin
    if (mem_req && !mem_we) mem_rdata <= load_pat(mem_addr);
    else                    mem_rdata <= {$urandom, $urandom};
  end

  int checks;
  int errors;
  int cyc;
  logic [64:0] exp_rows[$];
  logic [13:0] exp_raddr[$];
  logic [13:0] exp_waddr[$];
  logic [63:0] exp_wdata[$];
  int store_idx, cur_n;
  bit wready_toggle;
  int acc_cnt, acc1, acc2, dec_cnt, dec_cyc, exec_cnt, exec_cyc;
  int first_wv_cyc, first_rd_cyc, last_hs_cyc, load_hs_cnt;
  int memreq_cnt, wv_cnt, rv_cnt, busy_gap;
  bit prev_stall;
  logic [63:0] prev_wdata;
  logic prev_wlast;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    acc_cnt = 0; acc1 = -1; acc2 = -1; dec_cnt = 0; dec_cyc = -1;
    exec_cnt = 0; exec_cyc = -1; first_wv_cyc = -1; first_rd_cyc = -1;
    last_hs_cyc = -1; load_hs_cnt = 0; memreq_cnt = 0; wv_cnt = 0; rv_cnt = 0;
    busy_gap = 0; store_idx = 0;
  endtask

  task automatic push_load(input int base, input int n, input int stride);
    logic [13:0] a;
    for (int k = 0; k <= n; k++) begin
      a = 14'(base + k * stride);
      exp_raddr.push_back(a);
      exp_rows.push_back({k == n, load_pat(a)});
    end
  endtask

  task automatic push_store(input int base, input int n, input int stride);
    cur_n = n;
    for (int k = 0; k <= n; k++) begin
      exp_waddr.push_back(14'(base + k * stride));
      exp_wdata.push_back(store_pat(k));
    end
  endtask

  // One clock: drive per-cycle inputs, sample mid-cycle, then advance past the edge.
  task automatic cycle();
    logic [64:0] e;
    sload_wready = wready_toggle ? cyc[0] : 1'b1;
    sstore_rdata = store_pat(store_idx);
    #2;
    if (sinst_busy === 1'b0 && acc_cnt == 1) busy_gap++;
    if (sinst_wvalid && sinst_wready) begin
      acc_cnt++;
      if (acc_cnt == 1) acc1 = cyc; else acc2 = cyc;
    end
    if (sinst_decode_finish) begin dec_cnt++; dec_cyc = cyc; end
    if (sinst_execute_finish) begin exec_cnt++; exec_cyc = cyc; end
    if (sload_wvalid || sstore_rvalid)
      chk("valid_excl", 64'(sload_wvalid & sstore_rvalid), 64'(0));
    if (prev_stall) begin
      chk("hold_valid", 64'(sload_wvalid), 64'(1));
      chk("hold_data", sload_wdata, prev_wdata);
      chk("hold_last", 64'(sload_wlast), 64'(prev_wlast));
    end
    prev_stall = sload_wvalid && !sload_wready;
    prev_wdata = sload_wdata;
    prev_wlast = sload_wlast;
    if (sload_wvalid) begin
      wv_cnt++;
      if (first_wv_cyc < 0) first_wv_cyc = cyc;
    end
    if (sload_wvalid && sload_wready) begin
      load_hs_cnt++;
      last_hs_cyc = cyc;
      if (exp_rows.size() == 0) chk("load_extra", 64'(sload_wvalid), 64'(0));
      else begin
        e = exp_rows.pop_front();
        chk("load_data", sload_wdata, e[63:0]);
        chk("load_last", 64'(sload_wlast), 64'(e[64]));
      end
    end
    if (sstore_rvalid) begin
      rv_cnt++;
      chk("rlast", 64'(sstore_rlast), 64'(store_idx == cur_n));
    end
    if (mem_req) memreq_cnt++;
    if (mem_req && !mem_we) begin
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      if (exp_raddr.size() == 0) chk("read_extra", 64'(mem_req), 64'(0));
      else chk("read_addr", 64'(mem_addr), 64'(exp_raddr.pop_front()));
    end
    if (mem_req && mem_we) begin
      if (exp_waddr.size() == 0) chk("write_extra", 64'(mem_req), 64'(0));
      else begin
        chk("write_addr", 64'(mem_addr), 64'(exp_waddr.pop_front()));
        chk("write_data", mem_wdata, exp_wdata.pop_front());
      end
    end
    if (sstore_rvalid && sstore_rready) store_idx++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] inst);
    sinst_wvalid = 1'b1;
    sinst_wdata  = inst;
    for (int i = 0; i < 20 && acc_cnt == 0; i++) cycle();
    chk("accept", 64'(acc_cnt), 64'(1));
    sinst_wvalid = 1'b0;
  endtask

  task automatic wait_exec(input int want, input int limit);
    for (int i = 0; i < limit && exec_cnt < want; i++) cycle();
    cycle();
    cycle();
    chk("exec_count", 64'(exec_cnt), 64'(want));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({sinst_wready, sinst_decode_finish, sinst_execute_finish, sinst_busy,
                            sload_wvalid, sload_wlast, sstore_rvalid, sstore_rlast,
                            mem_req, mem_we}), 64'(0));
    chk({tag, "_wdata"}, sload_wdata, 64'(0));
    chk({tag, "_maddr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mwdata"}, mem_wdata, 64'(0));
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rstnn = 1'b0; sinst_wvalid = 1'b0; sinst_wdata = '0;
    sload_wready = 1'b1; sstore_rready = 1'b1; sstore_rdata = store_pat(7);
    wready_toggle = 1'b0; prev_stall = 1'b0; prev_wdata = '0; prev_wlast = 1'b0; cur_n = 0;
    clear_stats();

    // Reset state
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rstnn = 1'b1;
    sstore_rready = 1'b0;
    cycle();
    chk("idle_wready", 64'(sinst_wready), 64'(1));
    chk("idle_busy", 64'(sinst_busy), 64'(0));

    // LOAD base=0x10 nrows_m1=3 stride=2, no backpressure
    clear_stats();
    push_load('h10, 3, 2);
    send(mk_inst(1, 3, 2, 'h10));
    wait_exec(1, 60);
    chk("ld_decode_cyc", 64'(dec_cyc - acc1), 64'(1));
    chk("ld_first_read", 64'(first_rd_cyc - acc1), 64'(2));
    chk("ld_first_valid", 64'(first_wv_cyc - acc1), 64'(3));
    chk("ld_last_hs", 64'(last_hs_cyc - acc1), 64'(6));
    chk("ld_exec_cyc", 64'(exec_cyc - acc1), 64'(7));
    chk("ld_rows", 64'(load_hs_cnt), 64'(4));
    chk("ld_sb_empty", 64'(exp_rows.size() + exp_raddr.size()), 64'(0));

    // Same LOAD with wready toggling
    clear_stats();
    wready_toggle = 1'b1;
    push_load('h10, 3, 2);
    send(mk_inst(1, 3, 2, 'h10));
    wait_exec(1, 100);
    wready_toggle = 1'b0;
    chk("ldbp_rows", 64'(load_hs_cnt), 64'(4));
    chk("ldbp_sb_empty", 64'(exp_rows.size() + exp_raddr.size()), 64'(0));

    // STORE base=0x3FFE nrows_m1=2 stride=1, wraps to 0
    clear_stats();
    sstore_rready = 1'b1;
    push_store('h3FFE, 2, 1);
    send(mk_inst(2, 2, 1, 'h3FFE));
    wait_exec(1, 60);
    chk("st_exec_cyc", 64'(exec_cyc - acc1), 64'(5));
    chk("st_rows", 64'(rv_cnt), 64'(3));
    chk("st_sb_empty", 64'(exp_waddr.size()), 64'(0));

    // NOP op=11 with rready held high
    clear_stats();
    send(mk_inst(3, 5, 7, 'h123));
    wait_exec(1, 20);
    chk("nop_decode_cyc", 64'(dec_cyc - acc1), 64'(1));
    chk("nop_exec_cyc", 64'(exec_cyc - dec_cyc), 64'(1));
    chk("nop_memreq", 64'(memreq_cnt), 64'(0));
    chk("nop_valids", 64'(wv_cnt + rv_cnt), 64'(0));
    sstore_rready = 1'b0;

    // Reset in the middle of LOAD row 2
    clear_stats();
    push_load('h100, 7, 3);
    send(mk_inst(1, 7, 3, 'h100));
    for (int i = 0; i < 40 && load_hs_cnt < 2; i++) cycle();
    chk("rst_reach_row2", 64'(load_hs_cnt), 64'(2));
    chk("rst_row2_valid", 64'(sload_wvalid), 64'(1));
    rstnn = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_rows.delete();
    exp_raddr.delete();
    prev_stall = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_no_exec", 64'(exec_cnt), 64'(0));
    rstnn = 1'b1;
    cycle();
    clear_stats();
    wready_toggle = 1'b1;
    push_load('h20, 2, 1);
    send(mk_inst(1, 2, 1, 'h20));
    wait_exec(1, 60);
    wready_toggle = 1'b0;
    chk("postrst_rows", 64'(load_hs_cnt), 64'(3));
    chk("postrst_sb_empty", 64'(exp_rows.size() + exp_raddr.size()), 64'(0));

    // Back-to-back instructions with wvalid held high
    clear_stats();
    push_load('h40, 0, 1);
    sinst_wvalid = 1'b1;
    sinst_wdata  = mk_inst(1, 0, 1, 'h40);
    for (int i = 0; i < 20 && acc_cnt < 1; i++) cycle();
    sinst_wdata = mk_inst(0, 0, 0, 0);
    for (int i = 0; i < 40 && acc_cnt < 2; i++) cycle();
    sinst_wvalid = 1'b0;
    wait_exec(2, 20);
    chk("b2b_accepts", 64'(acc_cnt), 64'(2));
    chk("b2b_spacing", 64'(acc2 - acc1), 64'(5));
    chk("b2b_busy_gap", 64'(busy_gap), 64'(1));
    chk("b2b_rows", 64'(load_hs_cnt), 64'(1));
    chk("b2b_sb_empty", 64'(exp_rows.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
